ysyx_25040111_lsu: RTL and testbench
====================================

# ysyx_25040111_lsu

Load/store unit between the memory arbiter and the AXI4 system bus. Accepts one read request (single-beat load or cache-line burst) or one write request at a time from the arbiter. Drives the AXI4 master channels and aligns byte lanes. Returns sign/zero-extended load data, or a write acknowledge, through a registered one-cycle ready pulse.

## Interface
- No parameters. Data width 32, address width 32, AXI ID unused and tied 0.
- clock  in  1  single core clock
- reset  in  1  asynchronous, active-low reset
- req_rvalid  in  1  read request valid, held by the arbiter until req_rready
- req_rready  out  1  one-cycle pulse per returned beat; req_rdata valid in the same cycle
- req_rdata  out  32  aligned and extended load data, or raw beat for a burst
- req_raddr  in  32  read byte address
- req_rlen  in  8  AXI beats minus 1; honoured only when req_burst=1
- req_burst  in  1  1 = INCR word burst (cache refill)
- req_rmask  in  2  access size: 00 byte, 01 half, 10/11 word
- req_rsign  in  1  1 = sign-extend byte/half loads
- req_wvalid  in  1  write request valid, held until req_wready
- req_wready  out  1  one-cycle write-complete pulse
- req_wdata, req_waddr  in  32 each  store data (in the low lanes) and byte address
- req_wmask  in  2  store size, same encoding as req_rmask
- lsu_err  out  1  bus-error pulse (see Configuration)
- AXI4 master ports, all 1 bit unless stated:
  - AR: araddr 32, arvalid, arready, arlen 8, arsize 3, arburst 2
  - R: rvalid, rready, rdata 32, rresp 2, rlast
  - AW: awaddr 32, awvalid, awready, awsize 3
  - W: wdata 32, wstrb 4, wvalid, wready, wlast
  - B: bvalid, bready, bresp 2

## Operation
- States: IDLE, AR, R, AW_W, B, DONE.
- IDLE:
  - If req_rvalid: latch address, mask, sign and length; go to AR.
  - Otherwise, if req_wvalid: latch address, data and mask; go to AW_W.
  - Reads take priority when both are valid.
- AR:
  - arvalid=1, araddr = latched address.
  - arsize = 0/1/2 for mask 00/01/10-11.
  - arlen = rlen if burst, else 0. arburst = INCR (01).
  - On arready, go to R.
- R:
  - rready=1. Each beat is captured into a data register, and req_rready pulses in the following cycle.
  - Single beat: go to DONE.
  - Burst: stay in R until the beat with rlast, then go to DONE.
- AW_W:
  - awvalid and wvalid are asserted together. Each one drops independently on its own handshake.
  - wlast=1.
  - wstrb: byte = 0001<<a[1:0]; half = 0011<<{a[1],0}; word = 1111.
  - wdata = store data shifted left by 8×a[1:0].
  - When both channels have completed, go to B.
- B: bready=1. On bvalid, req_wready pulses next cycle; go to DONE.
- DONE: one cycle, then IDLE. This absorbs the arbiter's one-cycle-late deassertion of valid, so a request is never accepted twice.
- Load alignment (single-beat only):
  - The beat is shifted right by 8×a[1:0].
  - Byte/half results are sign-extended if rsign=1, else zero-extended.
  - Burst beats are returned unmodified.
- Misaligned accesses (half at a[0]=1, word at a[1:0]≠0) are issued as-is; the arbiter never generates them.

## Timing
- Reset values: all AXI valids/readies 0, req_rready 0, req_wready 0, req_rdata 0, lsu_err 0, state IDLE.
- Asserting reset mid-transaction aborts at once; the outstanding bus transaction is dropped.
- Load latency:
  - Request seen at cycle 0; arvalid at cycle 1.
  - With zero-wait arready and an R beat in cycle 2, req_rready pulses in cycle 3; IDLE at cycle 5.
- Burst of N beats: N req_rready pulses, each one cycle after its R beat. A stalled rvalid produces gaps.
- Store latency: awvalid/wvalid at cycle 1; with zero-wait slave, bvalid at cycle 2 and req_wready at cycle 3.
- AXI valids hold stable until their handshake; addresses and data never change while valid is high.
- req_rvalid or req_wvalid arriving outside IDLE is ignored.

## Configuration
- YSYX_25040111_LSU_RESP_CHK_EN defined:
  - A non-zero rresp on any beat, or a non-zero bresp, raises lsu_err for one cycle, aligned with the corresponding ready pulse.
  - The transaction still completes normally.
- Macro undefined: lsu_err is tied 0, and rresp/bresp are ignored.

## Test plan
- Signed byte load, raddr=0x8000_0003, mask=00, sign=1, bus word 0x80FF_1234 -> araddr=0x8000_0003, arsize=0, req_rdata=0xFFFF_FF80.
- Unsigned half load, raddr=…02, mask=01, sign=0, word 0xBEEF_0000 -> req_rdata=0x0000_BEEF.
- Burst, rlen=3, burst=1, slave beats 0x11/0x22/0x33/0x44 with 2 stall cycles before beat 3 -> arlen=3, arburst=01, four req_rready pulses carrying those values unmodified, then DONE→IDLE.
- Byte store, waddr=…01, wdata=0x0000_00AB, mask=00, with awready delayed 3 cycles after wready -> wstrb=0010, wdata=0x0000_AB00, single req_wready pulse after bvalid.
- Simultaneous req_rvalid and req_wvalid -> read is served first; the write starts only after DONE.
- With the macro defined, bresp=10 -> lsu_err and req_wready pulse together. Separately, reset asserted during R -> all outputs 0 and state IDLE immediately.

Source files
------------

// File: rtl/ysyx_25040111_lsu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_lsu
// Purpose  : Load/store unit between the memory arbiter and the AXI4 system
//            bus. Serves one read (single beat or INCR cache-line burst) or
//            one write at a time, aligns byte lanes, sign/zero-extends loads
//            and returns data / write acknowledge as a registered one-cycle
//            ready pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset          : core clock, asynchronous active-low reset
//   req_r*                : arbiter read request (valid/addr/len/burst/mask/
//                           sign) and response (rready pulse + rdata)
//   req_w*                : arbiter write request (valid/addr/data/mask) and
//                           completion pulse (wready)
//   lsu_err               : one-cycle bus-error pulse
//   ar*/r*/aw*/w*/b*      : AXI4 master channels (ID unused)
// ----------------------------------------------------------------------------
// Configuration macro
//   YSYX_25040111_LSU_RESP_CHK_EN : when defined, a non-zero RRESP on any
//       beat or a non-zero BRESP pulses lsu_err together with the matching
//       ready pulse. When undefined, lsu_err is tied 0 and responses are
//       ignored.
// ============================================================================
module ysyx_25040111_lsu (
    input  logic        clock,
    input  logic        reset,

    // arbiter read port
    input  logic        req_rvalid,
    output logic        req_rready,
    output logic [31:0] req_rdata,
    input  logic [31:0] req_raddr,
    input  logic [7:0]  req_rlen,
    input  logic        req_burst,
    input  logic [1:0]  req_rmask,
    input  logic        req_rsign,

    // arbiter write port
    input  logic        req_wvalid,
    output logic        req_wready,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_waddr,
    input  logic [1:0]  req_wmask,

    output logic        lsu_err,

    // AXI4 AR channel
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,

    // AXI4 R channel
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,

    // AXI4 AW channel
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [2:0]  awsize,

    // AXI4 W channel
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    output logic        wlast,

    // AXI4 B channel
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW_W = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;

    // request context captured in IDLE
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_mask;
    logic        r_sign;
    logic        r_burst;
    logic [7:0]  r_len;

    // per-channel write completion flags (AW and W may finish in any order)
    logic        r_aw_done;
    logic        r_w_done;

    // r_rfin marks the cycle after the final R beat: the ready pulse is
    // being presented and no further beat may be accepted.
    logic        r_rfin;
    logic        r_rready;
    logic        r_wready;
    logic [31:0] r_rdata;

    logic        w_r_hs;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_hs;
    logic        w_r_last;
    logic        w_aw_all;
    logic        w_w_all;
    logic [2:0]  w_size;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    assign w_r_hs   = rvalid  & rready;
    assign w_aw_hs  = awvalid & awready;
    assign w_w_hs   = wvalid  & wready;
    assign w_b_hs   = bvalid  & bready;

    // A single-beat read ends on its only beat regardless of RLAST.
    assign w_r_last = r_burst ? rlast : 1'b1;

    assign w_aw_all = r_aw_done | w_aw_hs;
    assign w_w_all  = r_w_done  | w_w_hs;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_rvalid) begin
                    w_next_state = S_AR;
                end else if (req_wvalid) begin
                    w_next_state = S_AW_W;
                end
            end
            S_AR: begin
                if (arready) begin
                    w_next_state = S_R;
                end
            end
            S_R: begin
                if (r_rfin) begin
                    w_next_state = S_DONE;
                end
            end
            S_AW_W: begin
                if (w_aw_all && w_w_all) begin
                    w_next_state = S_B;
                end
            end
            S_B: begin
                // leave once the acknowledge pulse is on the port
                if (r_wready) begin
                    w_next_state = S_DONE;
                end
            end
            // DONE swallows the arbiter's late valid deassertion
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded AXI handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (r_state)
            S_AR:   arvalid = 1'b1;
            S_R:    rready  = ~r_rfin;
            S_AW_W: begin
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
            end
            S_B:    bready  = ~r_wready;
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, completion flags, response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_mask    <= 2'd0;
            r_sign    <= 1'b0;
            r_burst   <= 1'b0;
            r_len     <= 8'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rfin    <= 1'b0;
            r_rready  <= 1'b0;
            r_wready  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_rready <= 1'b0;
            r_wready <= 1'b0;
            r_rfin   <= 1'b0;

            if (r_state == S_IDLE) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                if (req_rvalid) begin
                    r_addr  <= req_raddr;
                    r_mask  <= req_rmask;
                    r_sign  <= req_rsign;
                    r_burst <= req_burst;
                    r_len   <= req_burst ? req_rlen : 8'd0;
                end else if (req_wvalid) begin
                    r_addr  <= req_waddr;
                    r_mask  <= req_wmask;
                    r_wdata <= req_wdata;
                end
            end

            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end

            if (w_r_hs) begin
                r_rdata  <= r_burst ? rdata : w_load_data;
                r_rready <= 1'b1;
                r_rfin   <= w_r_last;
            end

            if (w_b_hs) begin
                r_wready <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load alignment and extension (single-beat reads)
    // ------------------------------------------------------------------
    always_comb begin
        w_shifted = rdata >> {r_addr[1:0], 3'b000};
        case (r_mask)
            2'b00:   w_load_data = {{24{r_sign & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load_data = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer size and store lane placement
    // ------------------------------------------------------------------
    always_comb begin
        case (r_mask)
            2'b00: begin
                w_size = 3'd0;
                wstrb  = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_size = 3'd1;
                wstrb  = 4'b0011 << {r_addr[1], 1'b0};
            end
            default: begin
                w_size = 3'd2;
                wstrb  = 4'b1111;
            end
        endcase
    end

    assign araddr     = r_addr;
    assign arlen      = r_len;
    assign arsize     = w_size;
    assign arburst    = 2'b01;

    assign awaddr     = r_addr;
    assign awsize     = w_size;
    assign wdata      = r_wdata << {r_addr[1:0], 3'b000};
    assign wlast      = 1'b1;

    assign req_rready = r_rready;
    assign req_wready = r_wready;
    assign req_rdata  = r_rdata;

    // ------------------------------------------------------------------
    // Bus-error reporting
    // ------------------------------------------------------------------
`ifdef YSYX_25040111_LSU_RESP_CHK_EN
    logic r_err;

    // registered alongside r_rready / r_wready so the pulses coincide
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_r_hs & (|rresp)) | (w_b_hs & (|bresp));
        end
    end

    assign lsu_err = r_err;
`else
    logic w_unused_resp;

    assign w_unused_resp = ^{rresp, bresp};
    assign lsu_err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040111_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25040111_lsu
// Purpose  : Self-checking bench for ysyx_25040111_lsu. Directed stimulus
//            pushes hand-computed responses into a scoreboard; a monitor pops
//            and compares on every req_rready / req_wready pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040111_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        req_rvalid = 1'b0;
    logic        req_rready;
    logic [31:0] req_rdata;
    logic [31:0] req_raddr = 32'd0;
    logic [7:0]  req_rlen = 8'd0;
    logic        req_burst = 1'b0;
    logic [1:0]  req_rmask = 2'd0;
    logic        req_rsign = 1'b0;
    logic        req_wvalid = 1'b0;
    logic        req_wready;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] req_waddr = 32'd0;
    logic [1:0]  req_wmask = 2'd0;
    logic        lsu_err;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'd0;
    logic        rlast = 1'b0;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [2:0]  awsize;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic        wlast;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [1:0]  bresp = 2'd0;

    always #5 clock = ~clock;

    ysyx_25040111_lsu dut (
        .clock      (clock),
        .reset      (reset),
        .req_rvalid (req_rvalid),
        .req_rready (req_rready),
        .req_rdata  (req_rdata),
        .req_raddr  (req_raddr),
        .req_rlen   (req_rlen),
        .req_burst  (req_burst),
        .req_rmask  (req_rmask),
        .req_rsign  (req_rsign),
        .req_wvalid (req_wvalid),
        .req_wready (req_wready),
        .req_wdata  (req_wdata),
        .req_waddr  (req_waddr),
        .req_wmask  (req_wmask),
        .lsu_err    (lsu_err),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .awsize     (awsize),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .wlast      (wlast),
        .bvalid     (bvalid),
        .bready     (bready),
        .bresp      (bresp)
    );

    typedef struct packed {
        logic        is_w;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] beats [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic err_of(input logic [1:0] resp);
`ifdef YSYX_25040111_LSU_RESP_CHK_EN
        return (resp != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic sel(input int which);
        case (which)
            0:       return arvalid;
            1:       return rready;
            2:       return awvalid;
            3:       return wvalid;
            default: return bready;
        endcase
    endfunction

    // Call from the posedge half of a cycle; returns at the negedge where
    // the selected signal is high (n = cycles waited), bounded.
    task automatic wait_hi(input int which, input string name, output int n);
        n = 0;
        @(negedge clock);
        while (!sel(which) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check({name, "_seen"}, 32'(sel(which)), 32'd1);
    endtask

    // Monitor: every returned beat / write acknowledge is matched in order.
    always @(negedge clock) begin : mon
        exp_t e;
        if (reset && (req_rready || req_wready)) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", {30'd0, req_rready, req_wready}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_kind", {30'd0, req_rready, req_wready}, e.is_w ? 32'd1 : 32'd2);
                if (!e.is_w) check("req_rdata", req_rdata, e.data);
                check("lsu_err", 32'(lsu_err), 32'(e.err));
            end
        end
    end

    // Slave side of a single-beat read already issued at cycle 0.
    task automatic load_bus(input logic [31:0] addr, input logic [2:0] exp_size,
                            input logic [31:0] word, input logic [1:0] resp);
        int n;
        wait_hi(0, "arvalid", n);
        check("ar_latency", 32'(n), 32'd1);
        check("araddr", araddr, addr);
        check("arsize", 32'(arsize), 32'(exp_size));
        check("arlen", 32'(arlen), 32'd0);
        check("arburst", 32'(arburst), 32'd1);
        check("aw_during_read", 32'(awvalid), 32'd0);
        arready = 1'b1;
        @(posedge clock); #1 arready = 1'b0;
        wait_hi(1, "rready", n);
        rvalid = 1'b1; rdata = word; rresp = resp; rlast = 1'b1;
        @(posedge clock); #1 rvalid = 1'b0; rresp = 2'd0; rlast = 1'b0;
        @(negedge clock);
        check("rready_pulse", 32'(req_rready), 32'd1);
        @(posedge clock); #1;
        @(negedge clock);
        check("rready_single", 32'(req_rready), 32'd0);
        // arbiter drops valid one cycle late
        @(posedge clock); #1 req_rvalid = 1'b0;
        @(negedge clock);
        check("no_reaccept_r", 32'(arvalid), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] mask, input logic sign,
                           input logic [31:0] word, input logic [1:0] resp,
                           input logic [2:0] exp_size, input logic [31:0] exp_data);
        req_raddr = addr; req_rmask = mask; req_rsign = sign;
        req_burst = 1'b0; req_rlen = 8'd0; req_rvalid = 1'b1;
        sb.push_back('{1'b0, exp_data, err_of(resp)});
        load_bus(addr, exp_size, word, resp);
    endtask

    // Slave side of a write already issued.
    task automatic store_bus(input logic [31:0] addr, input logic [2:0] exp_size,
                             input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                             input int awd, input int wd, input logic [1:0] resp,
                             input int exp_lat);
        int n;
        int k;
        bit aw_done;
        bit w_done;
        wait_hi(2, "awvalid", n);
        check("aw_latency", 32'(n), 32'(exp_lat));
        check("wvalid_with_aw", 32'(wvalid), 32'd1);
        check("wlast", 32'(wlast), 32'd1);
        check("awsize", 32'(awsize), 32'(exp_size));
        aw_done = 1'b0; w_done = 1'b0; k = 0;
        while (!(aw_done && w_done) && k < 40) begin
            check("awvalid_hold", 32'(awvalid), 32'(!aw_done));
            check("wvalid_hold", 32'(wvalid), 32'(!w_done));
            if (!aw_done) check("awaddr", awaddr, addr);
            if (!w_done) begin
                check("wstrb", 32'(wstrb), 32'(exp_strb));
                check("wdata", wdata, exp_wdata);
            end
            awready = !aw_done && (k >= awd);
            wready  = !w_done && (k >= wd);
            @(posedge clock);
            if (awready) aw_done = 1'b1;
            if (wready)  w_done  = 1'b1;
            #1 awready = 1'b0; wready = 1'b0;
            k++;
            if (!(aw_done && w_done)) @(negedge clock);
        end
        wait_hi(4, "bready", n);
        check("b_latency", 32'(n), 32'd0);
        bvalid = 1'b1; bresp = resp;
        @(posedge clock); #1 bvalid = 1'b0; bresp = 2'd0;
        @(negedge clock);
        check("wready_pulse", 32'(req_wready), 32'd1);
        @(posedge clock); #1;
        @(negedge clock);
        check("wready_single", 32'(req_wready), 32'd0);
        @(posedge clock); #1 req_wvalid = 1'b0;
        @(negedge clock);
        check("no_reaccept_w", 32'(awvalid), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] mask,
                            input int awd, input int wd, input logic [1:0] resp,
                            input logic [2:0] exp_size, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        req_waddr = addr; req_wdata = data; req_wmask = mask; req_wvalid = 1'b1;
        sb.push_back('{1'b1, 32'd0, err_of(resp)});
        store_bus(addr, exp_size, exp_strb, exp_wdata, awd, wd, resp, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        check({tag, "_rready"}, 32'(rready), 32'd0);
        check({tag, "_awvalid"}, 32'(awvalid), 32'd0);
        check({tag, "_wvalid"}, 32'(wvalid), 32'd0);
        check({tag, "_bready"}, 32'(bready), 32'd0);
        check({tag, "_req_rready"}, 32'(req_rready), 32'd0);
        check({tag, "_req_wready"}, 32'(req_wready), 32'd0);
        check({tag, "_req_rdata"}, req_rdata, 32'd0);
        check({tag, "_lsu_err"}, 32'(lsu_err), 32'd0);
    endtask

    initial begin : stim
        int n;
        beats[0] = 32'h0000_0011;
        beats[1] = 32'h0000_0022;
        beats[2] = 32'h0000_0033;
        beats[3] = 32'h0000_0044;

        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clock); #1;

        // single-beat loads
        do_load(32'h8000_0003, 2'b00, 1'b1, 32'h80FF_1234, 2'b00, 3'd0, 32'hFFFF_FF80);
        do_load(32'h8000_0002, 2'b01, 1'b0, 32'hBEEF_0000, 2'b00, 3'd1, 32'h0000_BEEF);
        do_load(32'h8000_0000, 2'b01, 1'b1, 32'h1234_8001, 2'b00, 3'd1, 32'hFFFF_8001);
        do_load(32'h8000_0010, 2'b10, 1'b1, 32'hDEAD_BEEF, 2'b10, 3'd2, 32'hDEAD_BEEF);
        do_load(32'h8000_0001, 2'b00, 1'b0, 32'h0000_9A00, 2'b00, 3'd0, 32'h0000_009A);

        // 4-beat burst with a 2-cycle stall before the third beat
        req_raddr = 32'h8000_0040; req_rmask = 2'b10; req_rsign = 1'b0;
        req_burst = 1'b1; req_rlen = 8'd3; req_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back('{1'b0, beats[i], err_of(i == 1 ? 2'b01 : 2'b00)});
        wait_hi(0, "burst_arvalid", n);
        check("burst_araddr", araddr, 32'h8000_0040);
        check("burst_arlen", 32'(arlen), 32'd3);
        check("burst_arburst", 32'(arburst), 32'd1);
        check("burst_arsize", 32'(arsize), 32'd2);
        arready = 1'b1;
        @(posedge clock); #1 arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) repeat (2) @(posedge clock);
            wait_hi(1, "burst_rready", n);
            rvalid = 1'b1; rdata = beats[i]; rlast = (i == 3);
            rresp = (i == 1) ? 2'b01 : 2'b00;
            @(posedge clock); #1 rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
        end
        @(posedge clock); #1;
        @(posedge clock); #1 req_rvalid = 1'b0; req_burst = 1'b0; req_rlen = 8'd0;
        @(negedge clock);
        check("burst_no_reaccept", 32'(arvalid), 32'd0);
        @(posedge clock); #1;

        // stores
        do_store(32'h8000_0001, 32'h0000_00AB, 2'b00, 3, 0, 2'b00, 3'd0, 4'b0010, 32'h0000_AB00);
        do_store(32'h8000_0002, 32'h0000_C0DE, 2'b01, 0, 0, 2'b10, 3'd1, 4'b1100, 32'hC0DE_0000);
        do_store(32'h8000_0004, 32'h1234_5678, 2'b11, 0, 0, 2'b00, 3'd2, 4'b1111, 32'h1234_5678);
        do_store(32'h8000_0003, 32'h0000_0055, 2'b00, 0, 2, 2'b00, 3'd0, 4'b1000, 32'h5500_0000);

        // simultaneous read and write: read first, write after DONE
        req_raddr = 32'h8000_0020; req_rmask = 2'b10; req_rsign = 1'b0; req_rvalid = 1'b1;
        req_waddr = 32'h8000_0024; req_wdata = 32'h0BAD_BEEF; req_wmask = 2'b10; req_wvalid = 1'b1;
        sb.push_back('{1'b0, 32'hCAFE_F00D, 1'b0});
        sb.push_back('{1'b1, 32'd0, 1'b0});
        load_bus(32'h8000_0020, 3'd2, 32'hCAFE_F00D, 2'b00);
        store_bus(32'h8000_0024, 3'd2, 4'b1111, 32'h0BAD_BEEF, 0, 0, 2'b00, 0);

        // reset in the middle of a read
        req_raddr = 32'h8000_0030; req_rmask = 2'b10; req_rvalid = 1'b1;
        wait_hi(0, "rst_arvalid", n);
        arready = 1'b1;
        @(posedge clock); #1 arready = 1'b0;
        wait_hi(1, "rst_rready", n);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        req_rvalid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("idle_after_reset", 32'(arvalid), 32'd0);
        @(posedge clock); #1;
        do_load(32'h8000_0002, 2'b00, 1'b0, 32'h0080_0000, 2'b00, 3'd0, 32'h0000_0080);

        repeat (4) @(posedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
